sync_fifo_flags: RTL and testbench
==================================

// Module: sync_fifo_flags
// PURPOSE
//  Parametrised single-clock FIFO, successor to the basic full/empty FIFO.
//  Adds programmable almost-full/almost-empty thresholds, an occupancy count,
//  sticky overflow/underflow error flags and an optional first-word-fall-through (FWFT) read mode.
//  Sits between a producer and a consumer in the same clock domain as the standard buffering element.
// PARAMETERS
//  DATA_WIDTH  8          width of each data word
//  DEPTH       8          number of entries; power of two, >= 2
//  AF_THRESH   DEPTH-2    almost_full is asserted when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH   2          almost_empty is asserted when count <= AE_THRESH (0..DEPTH-1)
//  FWFT        0          0 = standard registered read; 1 = first-word-fall-through
// PORTS
//  clk           in   1                 clock; everything is updated on the rising edge
//  rst           in   1                 synchronous, active-high reset
//  wr_en         in   1                 write request
//  wr_data       in   DATA_WIDTH        write data
//  rd_en         in   1                 read request (in FWFT mode: pop)
//  rd_data       out  DATA_WIDTH        read data
//  rd_valid      out  1                 rd_data holds a newly read word
//  full          out  1                 count == DEPTH
//  empty         out  1                 count == 0
//  almost_full   out  1                 count >= AF_THRESH
//  almost_empty  out  1                 count <= AE_THRESH
//  count         out  $clog2(DEPTH)+1   current occupancy, 0..DEPTH
//  overflow      out  1                 sticky flag: a write was attempted while full and was dropped
//  underflow     out  1                 sticky flag: a read was attempted while empty and was rejected
//  clr_err       in   1                 clears overflow and underflow
// BEHAVIOUR
//  - Reset (rst=1 at an edge): wr_ptr=rd_ptr=0; count=0; rd_data=0; rd_valid=0; overflow=underflow=0.
//    Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are not cleared.
//    Reset asserted mid-operation discards any read or write in that cycle.
//  - Pointers are $clog2(DEPTH) bits wide and wrap naturally. count is a register; all four flags decode
//    combinationally from count, so they reflect the state after the last clock edge.
//  - Write accepted (wr_ok) = wr_en & (~full | rd_ok): mem[wr_ptr] <= wr_data, then wr_ptr increments.
//  - Read accepted (rd_ok) = rd_en & ~empty: rd_ptr increments.
//  - count: +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither occur.
//  - When full, simultaneous wr_en and rd_en: both are accepted; count stays at DEPTH.
//  - When empty, simultaneous wr_en and rd_en: the write is accepted; the read is rejected and sets
//    underflow; count becomes 1. No bypass path from write to read.
//  - wr_en while full with no rd_ok: the data is dropped and overflow is set.
//    rd_en while empty: rd_data holds its last value, rd_valid=0, and underflow is set.
//  - overflow and underflow: cleared by clr_err. If a new error occurs in the same cycle as clr_err,
//    the set takes priority.
//  - FWFT=0: 1-cycle read latency. On rd_ok, rd_data <= mem[rd_ptr] and rd_valid=1 for the next cycle
//    only. At all other times rd_data holds its value.
//  - FWFT=1: rd_data = mem[rd_ptr] (combinational); rd_valid = ~empty. rd_en acts as a pop.
//    A word written into an empty FIFO appears on rd_data the cycle after its write.
// TESTING  (DEPTH=8, DATA_WIDTH=8, AF_THRESH=6, AE_THRESH=2 unless stated)
//  1 Reset, then write 0..7 -> almost_empty drops after the 3rd write; almost_full rises after the 6th;
//    full=1 and count=8 after the 8th. A 9th write of 0xAA -> dropped, overflow=1, count stays 8.
//  2 From the state of test 1, read 8 times -> rd_data 0..7 in order, each with rd_valid 1 cycle after rd_en;
//    empty=1 after the 8th read. A 9th read -> rd_data stays 7, rd_valid=0, underflow=1.
//    Then pulse clr_err -> overflow=underflow=0.
//  3 Full FIFO plus wr_en&rd_en with 0x33 -> oldest word is returned, count stays 8, 0x33 is read last.
//    Empty FIFO plus wr_en&rd_en with 0x5A -> count=1, underflow=1, next read returns 0x5A.
//  4 25 write-then-read pairs with $random data -> every readback equals the written value;
//    pointers wrap at least 3 times; empty=1 at the end.
//  5 Write 15, then assert rst for one cycle with rd_en=1 -> rd_data=0, rd_valid=0, count=0,
//    empty=1, error flags 0.
//  6 FWFT=1: write 0x11 then 0x22 -> rd_data=0x11 with rd_valid=1 the cycle after the first write,
//    without rd_en. Pop -> 0x22. Pop again -> empty=1, rd_valid=0.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and an optional first-word-fall-through read port.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_ok, rd_ok;

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        rd_ok    = rd_en & ~empty;
        // A read in the same cycle frees a slot, so a write to a full FIFO still lands.
        wr_ok    = wr_en & (~full | rd_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
        else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
        overflow_d  = (wr_en & ~wr_ok) | (overflow_q & ~clr_err);
        underflow_d = (rd_en & empty)  | (underflow_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

    if (FWFT) begin : g_fwft
        assign rd_data  = mem_q[rd_ptr_q];
        assign rd_valid = ~empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
        logic                  rd_valid_q, rd_valid_d;

        always_comb begin
            rd_data_d  = rd_data_q;
            rd_valid_d = rd_ok;
            if (rd_ok) rd_data_d = mem_q[rd_ptr_q];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_data_q  <= rd_data_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a standard-read and an FWFT instance share one stimulus stream
// and are compared every cycle against a queue-based model, plus directed literal checks.
module tb_sync_fifo_flags;

    localparam int DW = 8;
    localparam int DP = 8;
    localparam int AF = 6;
    localparam int AE = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          clr_err = 1'b0;

    logic [DW-1:0] s_rd_data, f_rd_data;
    logic          s_rd_valid, f_rd_valid;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [3:0]    s_count, f_count;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Reference model state
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_rd_data = '0;
    bit            m_rd_valid = 1'b0;
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf), .clr_err(clr_err)
    );

    sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int  n;
        bit  rd_ok, wr_ok;
        if (rst) begin
            mq.delete();
            m_rd_data  = '0;
            m_rd_valid = 1'b0;
            m_ovf      = 1'b0;
            m_unf      = 1'b0;
        end else begin
            n     = mq.size();
            rd_ok = rd_en && (n != 0);
            wr_ok = wr_en && ((n != DP) || rd_ok);
            m_ovf = (wr_en && !wr_ok) || (m_ovf && !clr_err);
            m_unf = (rd_en && n == 0) || (m_unf && !clr_err);
            m_rd_valid = rd_ok;
            if (rd_ok) m_rd_data = mq.pop_front();
            if (wr_ok) mq.push_back(wr_data);
        end
    end

    always @(negedge clk) begin
        int n;
        if (check_en) begin
            n = mq.size();
            check("count",        32'(s_count), 32'(n));
            check("full",         32'(s_full),  32'(n == DP));
            check("empty",        32'(s_empty), 32'(n == 0));
            check("almost_full",  32'(s_af),    32'(n >= AF));
            check("almost_empty", 32'(s_ae),    32'(n <= AE));
            check("overflow",     32'(s_ovf),   32'(m_ovf));
            check("underflow",    32'(s_unf),   32'(m_unf));
            check("rd_valid",     32'(s_rd_valid), 32'(m_rd_valid));
            check("rd_data",      32'(s_rd_data),  32'(m_rd_data));
            check("fwft_count",   32'(f_count), 32'(n));
            check("fwft_flags",   32'({f_full, f_empty, f_af, f_ae, f_ovf, f_unf}),
                  32'({n == DP, n == 0, n >= AF, n <= AE, m_ovf, m_unf}));
            check("fwft_rd_valid", 32'(f_rd_valid), 32'(n != 0));
            if (n != 0) check("fwft_rd_data", 32'(f_rd_data), 32'(mq[0]));
        end
    end

    task automatic step(input bit r, input bit w, input logic [DW-1:0] d, input bit rd, input bit c);
        rst = r; wr_en = w; wr_data = d; rd_en = rd; clr_err = c;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] d;
        @(negedge clk);
        step(1, 0, 0, 0, 0);
        check_en = 1'b1;
        check("reset_count", 32'(s_count), 0);
        check("reset_flags", 32'({s_empty, s_full, s_ae, s_af, s_ovf, s_unf, s_rd_valid}), 32'b1010000);

        // Fill 0..7, watch threshold crossings
        for (int i = 0; i < 8; i++) begin
            step(0, 1, DW'(i), 0, 0);
            if (i == 1) check("ae_after_2", 32'(s_ae), 1);
            if (i == 2) check("ae_after_3", 32'(s_ae), 0);
            if (i == 4) check("af_after_5", 32'(s_af), 0);
            if (i == 5) check("af_after_6", 32'(s_af), 1);
        end
        check("full_after_8", 32'({s_full, s_count}), 32'({1'b1, 4'd8}));
        step(0, 1, 8'hAA, 0, 0);
        check("overflow_drop", 32'({s_ovf, s_count}), 32'({1'b1, 4'd8}));

        // Drain in order, then underflow and clear
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 1, 0);
            check("drain_data", 32'({s_rd_valid, s_rd_data}), 32'({1'b1, 8'(i)}));
        end
        check("empty_after_8", 32'(s_empty), 1);
        step(0, 0, 0, 1, 0);
        check("underflow_read", 32'({s_rd_valid, s_rd_data, s_unf}), 32'({1'b0, 8'd7, 1'b1}));
        step(0, 0, 0, 0, 1);
        check("clr_err", 32'({s_ovf, s_unf}), 0);

        // Simultaneous read/write at full and at empty
        for (int i = 0; i < 8; i++) step(0, 1, DW'(8'h80 + i), 0, 0);
        step(0, 1, 8'h33, 1, 0);
        check("full_rw_data", 32'({s_rd_data, s_count}), 32'({8'h80, 4'd8}));
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);
        check("full_rw_last", 32'(s_rd_data), 32'h33);
        step(0, 1, 8'h5A, 1, 0);
        check("empty_rw", 32'({s_count, s_unf, s_rd_valid}), 32'({4'd1, 1'b1, 1'b0}));
        step(0, 0, 0, 1, 1);
        check("empty_rw_read", 32'(s_rd_data), 32'h5A);

        // Write-then-read pairs, wrapping pointers several times
        for (int i = 0; i < 25; i++) begin
            d = DW'($urandom);
            step(0, 1, d, 0, 0);
            step(0, 0, 0, 1, 0);
            check("pair_readback", 32'(s_rd_data), 32'(d));
        end
        check("pairs_empty", 32'(s_empty), 1);

        // Reset mid-operation with a pending read
        for (int i = 0; i < 15; i++) step(0, 1, DW'(8'hC0 + i), 0, 0);
        step(0, 0, 0, 1, 0);
        check("pre_reset_data", 32'(s_rd_data), 32'hC0);
        step(1, 0, 0, 1, 0);
        check("mid_reset", 32'({s_rd_data, s_rd_valid, s_count, s_empty, s_ovf, s_unf}),
              32'({8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0}));

        // FWFT behaviour
        step(0, 1, 8'h11, 0, 0);
        check("fwft_first", 32'({f_rd_valid, f_rd_data}), 32'({1'b1, 8'h11}));
        step(0, 1, 8'h22, 0, 0);
        check("fwft_hold", 32'(f_rd_data), 32'h11);
        step(0, 0, 0, 1, 0);
        check("fwft_pop1", 32'({f_rd_valid, f_rd_data}), 32'({1'b1, 8'h22}));
        step(0, 0, 0, 1, 0);
        check("fwft_pop2", 32'({f_empty, f_rd_valid}), 32'({1'b1, 1'b0}));

        // Random traffic with phases biased toward filling and draining
        for (int i = 0; i < 2000; i++) begin
            int wp;
            wp = ((i / 200) % 2 == 0) ? 70 : 30;
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 99) < wp,
                 DW'($urandom),
                 $urandom_range(0, 99) < (100 - wp),
                 $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
